uart_apb_sequencer: RTL
=======================

Name: uart_apb_sequencer

Overview:
APB master that owns the UART's APB slave port after reset. On start it writes a three-register configuration: divisor, line control, interrupt enable. It then serves a byte stream: for each accepted byte it polls the UART status register until TX-FIFO-not-full, then writes the byte to the TX data register. It sits between firmware-less traffic sources and uart_top, so the UART can be driven without a CPU.

Parameters:
APB_ADDR_WIDTH, 8, width of apb_addr_o
BASE_ADDR, 8'h00, UART base address added to every offset
OFF_DIV, 8'h00, divisor register offset
OFF_LCR, 8'h04, line control register offset
OFF_IER, 8'h08, interrupt enable register offset
OFF_STAT, 8'h0C, status register offset
OFF_TXD, 8'h10, TX data register offset
TXFULL_BIT, 0, bit index of TX-FIFO-full in status
TIMEOUT_CYCLES, 64, pready wait limit (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start_i  in  1  single-cycle pulse; begins configuration
div_i  in  16  divisor value, sampled on accepted start_i
lcr_i  in  8  line control value, sampled on accepted start_i
ier_i  in  8  interrupt enable value, sampled on accepted start_i
cfg_done_o  out  1  high while configured and serving bytes
err_o  out  1  sticky error flag
tx_data_i  in  8  byte to send
tx_valid_i  in  1  byte valid
tx_ready_o  out  1  byte accepted when valid&&ready
apb_addr_o  out  APB_ADDR_WIDTH  APB address
apb_sel_o  out  1  psel
apb_en_o  out  1  penable
apb_wr_o  out  1  pwrite
apb_wdata_o  out  32  write data, zero-extended
apb_strb_o  out  4  always 4'hF on writes, 4'h0 on reads
apb_rdata_i  in  32  read data
apb_ready_i  in  1  pready
apb_err_i  in  1  pslverr, sampled only when pready is high

Behaviour:
- Reset: all outputs 0 and state IDLE. Sampled config registers and the byte latch are cleared.
- States: IDLE, CFG_SETUP, CFG_ACCESS, READY, POLL_SETUP, POLL_ACCESS, TX_SETUP, TX_ACCESS.
- Every APB transfer has a one-cycle SETUP phase (sel=1, en=0), then ACCESS (sel=1, en=1) held until apb_ready_i=1. Address, write and data are stable across both phases. sel and en drop to 0 in the cycle after completion; no back-to-back transfers.
- start_i is accepted only in IDLE, or in READY with no byte latched. Accepting it:
  - samples div_i, lcr_i and ier_i;
  - clears err_o and cfg_done_o;
  - sets index=0 and moves to CFG_SETUP.
  - start_i in any other state is ignored.
- Configuration writes, in order: index 0 writes OFF_DIV with div_i; index 1 writes OFF_LCR with lcr_i; index 2 writes OFF_IER with ier_i.
  - After the index-2 write completes: enter READY and set cfg_done_o=1 in that same cycle.
  - After an index-0 or index-1 write completes: increment index and return to CFG_SETUP.
- READY: tx_ready_o = (state==READY) && cfg_done_o. This is combinational from state; it does not depend on tx_valid_i. On valid&&ready the byte is latched and the state moves to POLL_SETUP; no further byte is accepted until it is sent.
- POLL: read OFF_STAT.
  - If apb_rdata_i[TXFULL_BIT]=1 at completion: return to POLL_SETUP, with no idle gap beyond the mandatory one.
  - If the bit is 0: go to TX_SETUP.
- TX: write OFF_TXD with {24'b0, byte}, then return to READY.
- Byte latency with pready tied high and FIFO not full: accept cycle, then 2 cycles poll, then 2 cycles write; tx_ready_o reasserts 5 cycles after acceptance.
- pslverr during CFG: abort, set err_o=1, go to IDLE, cfg_done_o stays 0.
- pslverr during POLL or TX: drop the byte, set err_o=1, go to READY, cfg_done_o stays 1.
- err_o clears only on rst or an accepted start_i.
- rst mid-transfer: sel and en go to 0 next cycle; the transfer is abandoned with no completion.

Optional Feature:
UART_SEQ_TIMEOUT_EN:
- Defined: a counter runs during each ACCESS phase. If apb_ready_i stays low for TIMEOUT_CYCLES consecutive ACCESS cycles, the transfer is abandoned: sel and en drop next cycle and the pslverr path is taken (err_o=1, CFG→IDLE, POLL/TX→READY with the byte dropped). The counter resets at each SETUP.
- Undefined: no counter; ACCESS waits indefinitely; TIMEOUT_CYCLES is unused.

Test Plan:
- Config, zero-wait slave: start_i with div=16'h0145, lcr=8'h03, ier=8'h01 → writes 0x00=0x145, 0x04=0x03, 0x08=0x01 in order, each SETUP then ACCESS; cfg_done_o=1 in cycle 7 after start.
- Single byte: send 8'hA5, status reads 0 → read of 0x0C, then write 0x10=0x000000A5; tx_ready_o reasserts 5 cycles after acceptance.
- FIFO full: status returns bit0=1 for 3 polls then 0 → 4 reads of 0x0C, one write of the byte, no byte lost, tx_ready_o low throughout.
- Wait states: apb_ready_i low for 4 cycles on the LCR write → sel, en, addr and data stay stable for all 5 ACCESS cycles; the next write follows normally.
- Errors: pslverr on the IER write → err_o=1, cfg_done_o=0, state IDLE. A new start_i clears err_o and redoes the 3 writes. pslverr on TXD → err_o=1, cfg_done_o remains 1, and the next byte is accepted.
- With UART_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8: pready held low → sel drops after 8 ACCESS cycles and err_o=1. Without the macro: sel stays high for 100+ cycles.

Source files
------------

// File: rtl/uart_apb_sequencer.sv
// uart_apb_sequencer: APB master that owns the UART slave port. After start it
// writes divisor, line control and interrupt enable, then forwards a byte
// stream, polling the status register until the TX FIFO has room before each
// TX data write.
// Build option: define UART_SEQ_TIMEOUT_EN to abandon an ACCESS phase after
// TIMEOUT_CYCLES cycles of pready low; the abandoned transfer is handled like
// pslverr.
//
// state       | meaning
// IDLE        | not configured, waiting for start_i
// CFG_SETUP   | setup phase of configuration write [idx]
// CFG_ACCESS  | access phase of configuration write [idx]
// READY       | configured, waiting for a byte
// POLL_SETUP  | setup phase of status read
// POLL_ACCESS | access phase of status read
// TX_SETUP    | setup phase of TX data write
// TX_ACCESS   | access phase of TX data write
module uart_apb_sequencer #(
  parameter int                        APB_ADDR_WIDTH = 8,
  parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = 8'h00,
  parameter logic [APB_ADDR_WIDTH-1:0] OFF_DIV        = 8'h00,
  parameter logic [APB_ADDR_WIDTH-1:0] OFF_LCR        = 8'h04,
  parameter logic [APB_ADDR_WIDTH-1:0] OFF_IER        = 8'h08,
  parameter logic [APB_ADDR_WIDTH-1:0] OFF_STAT       = 8'h0C,
  parameter logic [APB_ADDR_WIDTH-1:0] OFF_TXD        = 8'h10,
  parameter int                        TXFULL_BIT     = 0,
  parameter int                        TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [15:0]               div_i,
  input  logic [7:0]                lcr_i,
  input  logic [7:0]                ier_i,
  output logic                      cfg_done_o,
  output logic                      err_o,
  input  logic [7:0]                tx_data_i,
  input  logic                      tx_valid_i,
  output logic                      tx_ready_o,
  output logic [APB_ADDR_WIDTH-1:0] apb_addr_o,
  output logic                      apb_sel_o,
  output logic                      apb_en_o,
  output logic                      apb_wr_o,
  output logic [31:0]               apb_wdata_o,
  output logic [3:0]                apb_strb_o,
  input  logic [31:0]               apb_rdata_i,
  input  logic                      apb_ready_i,
  input  logic                      apb_err_i
);

  typedef enum logic [2:0] {
    IDLE, CFG_SETUP, CFG_ACCESS, READY, POLL_SETUP, POLL_ACCESS, TX_SETUP, TX_ACCESS
  } state_t;

  state_t state_q, state_d;
  logic [1:0]  idx_q;
  logic [15:0] div_q;
  logic [7:0]  lcr_q, ier_q, byte_q;
  logic        cfg_done_q, err_q;

  logic in_setup, in_access, start_acc, byte_acc, xfer_ok, xfer_fail, timeout;
  logic [APB_ADDR_WIDTH-1:0] offset;
  logic [31:0] wdata;
  logic        wr;

  assign in_setup  = state_q inside {CFG_SETUP, POLL_SETUP, TX_SETUP};
  assign in_access = state_q inside {CFG_ACCESS, POLL_ACCESS, TX_ACCESS};
  // A byte is never held in READY, so start is legal there at any time.
  assign start_acc = start_i && (state_q == IDLE || state_q == READY);
  // start_i wins over a byte offered in the same READY cycle.
  assign byte_acc  = tx_valid_i && tx_ready_o && !start_acc;
  // pslverr only counts with pready; a timeout can only fire with pready low.
  assign xfer_fail = in_access && ((apb_ready_i && apb_err_i) || timeout);
  assign xfer_ok   = in_access && apb_ready_i && !apb_err_i;

`ifdef UART_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_q;

  // Down-counter reloaded in every SETUP; terminal count with pready low aborts.
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else if (in_setup) tmo_q <= TW'(TIMEOUT_CYCLES - 1);
    else if (in_access && !apb_ready_i && tmo_q != '0) tmo_q <= tmo_q - 1'b1;
  end

  assign timeout = in_access && !apb_ready_i && (tmo_q == '0);
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:        if (start_acc) state_d = CFG_SETUP;
      CFG_SETUP:   state_d = CFG_ACCESS;
      CFG_ACCESS: begin
        if (xfer_fail)    state_d = IDLE;
        else if (xfer_ok) state_d = (idx_q == 2'd2) ? READY : CFG_SETUP;
      end
      READY: begin
        if (start_acc)     state_d = CFG_SETUP;
        else if (byte_acc) state_d = POLL_SETUP;
      end
      POLL_SETUP:  state_d = POLL_ACCESS;
      POLL_ACCESS: begin
        if (xfer_fail)    state_d = READY;
        else if (xfer_ok) state_d = apb_rdata_i[TXFULL_BIT] ? POLL_SETUP : TX_SETUP;
      end
      TX_SETUP:    state_d = TX_ACCESS;
      TX_ACCESS:   if (xfer_fail || xfer_ok) state_d = READY;
      default:     state_d = IDLE;
    endcase
  end

  // Address, direction and data are a function of state only, so they hold
  // steady through SETUP and every wait cycle of ACCESS.
  always_comb begin
    offset = '0;
    wdata  = '0;
    wr     = 1'b0;
    unique case (state_q)
      CFG_SETUP, CFG_ACCESS: begin
        wr = 1'b1;
        unique case (idx_q)
          2'd0:    begin offset = OFF_DIV; wdata = {16'h0, div_q}; end
          2'd1:    begin offset = OFF_LCR; wdata = {24'h0, lcr_q}; end
          default: begin offset = OFF_IER; wdata = {24'h0, ier_q}; end
        endcase
      end
      POLL_SETUP, POLL_ACCESS: offset = OFF_STAT;
      TX_SETUP, TX_ACCESS: begin
        wr     = 1'b1;
        offset = OFF_TXD;
        wdata  = {24'h0, byte_q};
      end
      default: ;
    endcase
  end

  assign apb_sel_o   = in_setup || in_access;
  assign apb_en_o    = in_access;
  assign apb_addr_o  = apb_sel_o ? (BASE_ADDR + offset) : '0;
  assign apb_wr_o    = wr;
  assign apb_wdata_o = wdata;
  assign apb_strb_o  = wr ? 4'hF : 4'h0;
  assign cfg_done_o  = cfg_done_q;
  assign err_o       = err_q;
  assign tx_ready_o  = (state_q == READY) && cfg_done_q;

  logic unused_rdata;
  assign unused_rdata = ^apb_rdata_i;

  // State register, sampled configuration, byte latch and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      div_q      <= '0;
      lcr_q      <= '0;
      ier_q      <= '0;
      byte_q     <= '0;
      cfg_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        div_q      <= div_i;
        lcr_q      <= lcr_i;
        ier_q      <= ier_i;
        idx_q      <= '0;
        cfg_done_q <= 1'b0;
        err_q      <= 1'b0;
      end
      if (state_q == CFG_ACCESS && xfer_ok) begin
        if (idx_q == 2'd2) cfg_done_q <= 1'b1;
        else               idx_q      <= idx_q + 2'd1;
      end
      if (xfer_fail) err_q <= 1'b1;
      if (byte_acc)  byte_q <= tx_data_i;
    end
  end

endmodule
